// File: rtl/operand_fetch.sv
// Operand fetch stage: 32x32 register file, shift-aware operand selection and a
// single-entry valid/ready output register. Define OPERAND_FETCH_BYPASS_EN to forward same-edge write-back data.
module operand_fetch #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instruction,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB
);

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    logic [DATA_W-1:0] gpr [0:31];

    logic              vld_p0;
    logic [31:0]       instr_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;

    logic              accept;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [5:0]        funct;
    logic              is_rtype;
    logic              shift_imm;
    logic              shift_var;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;
    logic [31:0]       instr_nxt;

    assign in_ready    = !vld_p0 || out_ready;
    assign accept      = in_valid && in_ready;
    assign out_valid   = vld_p0;
    assign instruction = instr_p0;
    assign regA        = a_p0;
    assign regB        = b_p0;

    assign rs    = in_instruction[25:21];
    assign rt    = in_instruction[20:16];
    assign funct = in_instruction[5:0];

    // Register file: index 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_val = (rs == 5'd0) ? '0 : gpr[rs];
        rt_val = (rt == 5'd0) ? '0 : gpr[rt];
`ifdef OPERAND_FETCH_BYPASS_EN
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs)) rs_val = wb_data;
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rt)) rt_val = wb_data;
`endif
    end

    always_comb begin
        is_rtype  = (in_instruction[31:26] == 6'd0);
        shift_imm = is_rtype && ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
        shift_var = is_rtype && ((funct == FN_SLLV) || (funct == FN_SRLV) || (funct == FN_SRAV));
        a_nxt     = rs_val;
        b_nxt     = rt_val;
        instr_nxt = {in_instruction[31:26], 5'd0, 5'd1, in_instruction[15:0]};
        // Shifts carry the shifted value in rt; the rs/rt fields are re-encoded as ALU mode flags
        if (shift_imm) begin
            a_nxt     = rt_val;
            b_nxt     = '0;
            instr_nxt = {in_instruction[31:26], 5'd0, 5'd0, in_instruction[15:0]};
        end else if (shift_var) begin
            a_nxt     = rt_val;
            b_nxt     = rs_val;
            instr_nxt = {in_instruction[31:26], 5'd1, 5'd0, in_instruction[15:0]};
        end
    end

    // Stage p0: output register, loads on accept and holds under backpressure
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            instr_p0 <= '0;
            a_p0     <= '0;
            b_p0     <= '0;
        end else if (accept) begin
            vld_p0   <= 1'b1;
            instr_p0 <= instr_nxt;
            a_p0     <= a_nxt;
            b_p0     <= b_nxt;
        end else if (vld_p0 && out_ready) begin
            vld_p0   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table driven through a
// scoreboard queue, plus backpressure, bypass and reset-mid-handshake sequences.
module tb_operand_fetch;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] regA;
    logic [31:0] regB;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] exp_instr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [0:10];
    vec_t sb_q [$];
    int   errors = 0;
    int   checks = 0;
    int   sent = 0;
    int   received = 0;

    operand_fetch dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instruction(in_instruction),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .instruction   (instruction),
        .regA          (regA),
        .regB          (regB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: a transfer happens at the next rising edge whenever valid and ready are both high
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                received++;
                check("instruction", instruction, e.exp_instr);
                check("regA", regA, e.exp_a);
                check("regB", regB, e.exp_b);
            end
        end
    end

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clock);
        #1;
        wb_en = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instruction = v.instr;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            sb_q.push_back(v);
            sent++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        vec_t a;
        vec_t b;
        vec_t by;
        // {instruction, expected rewritten instruction, expected regA, expected regB}
        vecs[0]  = '{32'h00640820, 32'h00010820, 32'h00000005, 32'h00000007}; // add $1,$3,$4
        vecs[1]  = '{32'h00020900, 32'h00000900, 32'hFF0000FF, 32'h00000000}; // sll $1,$2,4
        vecs[2]  = '{32'h00A20804, 32'h00200804, 32'hFF0000FF, 32'h00000004}; // sllv $1,$2,$5
        vecs[3]  = '{32'h00830882, 32'h00000882, 32'h00000005, 32'h00000000}; // srl, stray rs
        vecs[4]  = '{32'h000717C3, 32'h000017C3, 32'h80000000, 32'h00000000}; // sra $2,$7,31
        vecs[5]  = '{32'h00642807, 32'h00202807, 32'h00000007, 32'h00000005}; // srav $5,$4,$3
        vecs[6]  = '{32'h00A70006, 32'h00200006, 32'h80000000, 32'h00000004}; // srlv $0,$7,$5
        vecs[7]  = '{32'h20611234, 32'h20011234, 32'h00000005, 32'h00000000}; // addi $1,$3,0x1234
        vecs[8]  = '{32'h8C440000, 32'h8C010000, 32'hFF0000FF, 32'h00000007}; // lw, funct bits zero
        vecs[9]  = '{32'h00451801, 32'h00011801, 32'hFF0000FF, 32'h00000004}; // R-type funct 1
        vecs[10] = '{32'h00030820, 32'h00010820, 32'h00000000, 32'h00000005}; // add $1,$0,$3

        reset = 1'b1;
        in_valid = 1'b0;
        in_instruction = '0;
        wb_en = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_instruction", instruction, 32'd0);
        check("rst_regA", regA, 32'd0);
        check("rst_regB", regB, 32'd0);
        @(posedge clock);
        #1;

        wb(5'd2, 32'hFF0000FF);
        wb(5'd3, 32'd5);
        wb(5'd4, 32'd7);
        wb(5'd5, 32'd4);
        wb(5'd7, 32'h80000000);
        wb(5'd0, 32'hFFFFFFFF);

        for (int i = 0; i < 11; i++) begin
            send(vecs[i]);
        end
        drain();

        // Backpressure: first op held for three cycles, second must wait then load exactly once
        a = vecs[0];
        b = vecs[5];
        out_ready = 1'b0;
        send(a);
        in_valid = 1'b1;
        in_instruction = b.instr;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_instr", instruction, a.exp_instr);
            check("bp_hold_regA", regA, a.exp_a);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        send(b);
        drain();

        // Write-back on the accept edge of a reader of the same register
        by.instr = 32'h20C10001;
        by.exp_instr = 32'h20010001;
`ifdef OPERAND_FETCH_BYPASS_EN
        by.exp_a = 32'h7FFFFFFF;
`else
        by.exp_a = 32'h00000000;
`endif
        by.exp_b = 32'h0;
        wb_en = 1'b1;
        wb_addr = 5'd6;
        wb_data = 32'h7FFFFFFF;
        send(by);
        wb_en = 1'b0;
        send('{32'h00C00820, 32'h00010820, 32'h7FFFFFFF, 32'h00000000});
        drain();

        // Reset while an output is held: it is discarded and the register file clears
        out_ready = 1'b0;
        send(vecs[0]);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb_q.delete();
        sent--;
        @(negedge clock);
        check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst2_instruction", instruction, 32'd0);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        send('{32'h00640820, 32'h00010820, 32'h00000000, 32'h00000000});
        drain();

        check("transfer_count", received, sent);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port in_valid  input  1  upstream instruction present.
REQ-004 SHALL have port in_ready  output  1  block accepts the instruction this cycle.
REQ-005 SHALL have port in_instruction  input  32  raw MIPS instruction word.
REQ-006 SHALL have port wb_en  input  1  write-back strobe.
REQ-007 SHALL have port wb_addr  input  5  write-back register index.
REQ-008 SHALL have port wb_data  input  32  write-back value.
REQ-009 SHALL have port out_valid  output  1  instruction/regA/regB hold a valid ALU operation.
REQ-010 SHALL have port out_ready  input  1  downstream ALU stage consumes the output this cycle.
REQ-011 SHALL have port instruction  output  32  rewritten instruction for the ALU.
REQ-012 SHALL have port regA  output  32  first ALU operand.
REQ-013 SHALL have port regB  output  32  second ALU operand.

Function
REQ-014 SHALL contain a 32 x 32-bit register file; index 0 reads as 0 and ignores writes.
REQ-015 SHALL write wb_data to GPR[wb_addr] on each rising edge with wb_en=1 (wb_addr!=0), independent of handshake state.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational, single-entry skid-free stage).
REQ-017 SHALL accept on a cycle with in_valid && in_ready; output registers load on that edge, 1-cycle latency to out_valid=1.
REQ-018 SHALL hold instruction/regA/regB/out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL clear out_valid on an edge with out_valid && out_ready && !(in_valid); back-to-back accept keeps out_valid=1.
REQ-020 SHALL, for R-type funct 000000/000010/000011 (sll/srl/sra): regA=GPR[rt], regB=0, output rs field=00000, rt field=00000.
REQ-021 SHALL, for R-type funct 000100/000110/000111 (sllv/srlv/srav): regA=GPR[rt], regB=GPR[rs], output rs field=00001, rt field=00000.
REQ-022 SHALL, for all other instructions: regA=GPR[rs], regB=GPR[rt], output rs field=00000, rt field=00001.
REQ-023 SHALL pass opcode, rd, shamt, funct and immediate bits (31:26, 15:0) unmodified.
REQ-024 SHALL sample the register file at the accepting edge; later write-backs do not alter held operands.

Reset
REQ-025 SHALL on reset: out_valid=0, instruction=0, regA=0, regB=0, all 32 GPRs=0.
REQ-026 SHALL give reset priority over accept and write-back on the same edge; a held output is discarded mid-handshake.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL support macro OPERAND_FETCH_BYPASS_EN.
REQ-029 With OPERAND_FETCH_BYPASS_EN defined: on an accept edge where wb_en=1 and wb_addr equals a read index (!=0), the operand SHALL take wb_data.
REQ-030 Without OPERAND_FETCH_BYPASS_EN: the operand SHALL take the pre-write GPR value; register-file write still occurs.

Verification
REQ-031 Reset, write GPR3=5, GPR4=7, accept add $1,$3,$4 (000000_00011_00100_00001_00000_100000) -> next cycle out_valid=1, regA=5, regB=7, instruction=000000_00000_00001_00001_00000_100000.
REQ-032 GPR2=0xFF0000FF, accept sll $1,$2,4 -> regA=0xFF0000FF, regB=0, rs/rt fields=00000/00000, shamt=00100.
REQ-033 GPR5=4, GPR2=0xFF0000FF, accept sllv $1,$2,$5 -> regA=0xFF0000FF, regB=4, rs field=00001, rt field=00000.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> next instruction loads next edge, no loss or duplication.
REQ-035 Accept addi $1,$6,1 while wb_en=1, wb_addr=6, wb_data=0x7FFFFFFF, GPR6 previously 0 -> regA=0x7FFFFFFF with OPERAND_FETCH_BYPASS_EN, regA=0 without; GPR6=0x7FFFFFFF afterwards in both.
REQ-036 Write wb_addr=0, wb_data=0xFFFFFFFF, accept add using rs=0 -> regA=0; reset asserted while out_valid=1, out_ready=0 -> out_valid=0 next edge.
